// File: rtl/slice_reg_pkg.sv
// Shared types for the slice register stage: config word layout, mode encodings, cfg FSM states.
// Optional readback port on slice_reg_pair is enabled by defining SLICE_READBACK_EN.
package slice_reg_pkg;

  localparam int CFG_BITS = 6;

  localparam int BIT_REGSET  = 0;
  localparam int BIT_SEL     = 1;
  localparam int BIT_LSRMODE = 2;
  localparam int BIT_GSR     = 3;
  localparam int BIT_SRMODE  = 4;
  localparam int BIT_CEMUX   = 5;

  typedef enum logic {
    REGSET_RESET = 1'b0,
    REGSET_SET   = 1'b1
  } regset_e;

  typedef enum logic {
    SRMODE_LSR_OVER_CE = 1'b0,
    SRMODE_ASYNC       = 1'b1
  } srmode_e;

  typedef enum logic {
    LSRMODE_LSR  = 1'b0,
    LSRMODE_PRLD = 1'b1
  } lsrmode_e;

  // Packed MSB-first so that the struct matches the raw word bit for bit.
  typedef struct packed {
    logic     cemux;
    srmode_e  srmode;
    logic     gsr;
    lsrmode_e lsrmode;
    logic     sel;
    regset_e  regset;
  } cfg_t;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_COMMIT = 1'b1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic cfg_t cfg_unpack(input logic [CFG_BITS-1:0] w);
    cfg_t c;
    c.regset  = regset_e'(w[BIT_REGSET]);
    c.sel     = w[BIT_SEL];
    c.lsrmode = lsrmode_e'(w[BIT_LSRMODE]);
    c.gsr     = w[BIT_GSR];
    c.srmode  = srmode_e'(w[BIT_SRMODE]);
    c.cemux   = w[BIT_CEMUX];
    return c;
  endfunction

endpackage

// File: rtl/slice_reg_pair_if.sv
// Config port of the slice register stage: shadow writes, commit request and FSM status.
interface slice_reg_pair_if
  import slice_reg_pkg::*;
#(
  parameter int NREG = 2,
  parameter int CFGW = CFG_BITS
);
  localparam int IDXW = idx_width(NREG);

  // Handshake: a write transfers on a rising edge where cfg_valid && cfg_ready;
  // cfg_idx/cfg_data must be stable while cfg_valid is high. cfg_commit is a level
  // sampled only in IDLE; cfg_busy marks the single COMMIT cycle (cfg_ready low).
  logic            cfg_valid;
  logic            cfg_ready;
  logic [IDXW-1:0] cfg_idx;
  logic [CFGW-1:0] cfg_data;
  logic            cfg_commit;
  logic            cfg_busy;
  logic [0:0]      cfg_state;

  modport master (
    output cfg_valid, cfg_idx, cfg_data, cfg_commit,
    input  cfg_ready, cfg_busy, cfg_state
  );

  modport slave (
    input  cfg_valid, cfg_idx, cfg_data, cfg_commit,
    output cfg_ready, cfg_busy, cfg_state
  );

endinterface

// File: rtl/slice_reg_bit.sv
// One slice register: LSR/CE/SEL muxing in front of the flop plus the zero-latency ASYNC output mask.
module slice_reg_bit
  import slice_reg_pkg::*;
(
  input  logic clk,
  input  logic gsr_n,
  input  logic ce,
  input  logic lsr,
  input  logic df,
  input  logic di,
  input  cfg_t cfg,
  output logic q
);

  logic q_ff;
  logic sr_val;
  logic ce_eff;
  logic d_sel;
  logic unused_gsr;

  // GSR only matters through the reset-cleared config, so the bit is not consulted here.
  assign unused_gsr = cfg.gsr;

  assign sr_val = (cfg.lsrmode == LSRMODE_PRLD) ? di : cfg.regset;
  assign ce_eff = cfg.cemux | ce;
  assign d_sel  = cfg.sel ? di : df;

  always_ff @(posedge clk or negedge gsr_n) begin
    if (!gsr_n) begin
      q_ff <= 1'b0;
    end else if (lsr) begin
      q_ff <= sr_val;
    end else if (ce_eff) begin
      q_ff <= d_sel;
    end
  end

  assign q = ((cfg.srmode == SRMODE_ASYNC) && lsr) ? sr_val : q_ff;

endmodule

// File: rtl/slice_reg_pair.sv
// Slice register stage: NREG slice_reg_bit flops, shadow/active config with a one-cycle commit FSM.
// Define SLICE_READBACK_EN to add the rb_* port returning {Q[idx], active[idx]} one cycle after rb_req.
module slice_reg_pair
  import slice_reg_pkg::*;
#(
  parameter int NREG = 2,
  parameter int CFGW = CFG_BITS,
  localparam int IDXW = idx_width(NREG)
) (
  input  logic            CLK,
  input  logic            GSR_N,
  input  logic            CE,
  input  logic            LSR,
  input  logic [NREG-1:0] DF,
  input  logic [NREG-1:0] DI,
  output logic [NREG-1:0] Q,
  slice_reg_pair_if.slave cfg
`ifdef SLICE_READBACK_EN
  ,
  input  logic            rb_req,
  input  logic [IDXW-1:0] rb_idx,
  output logic            rb_valid,
  output logic [CFGW:0]   rb_data
`endif
);

  logic [0:0]      state;
  cfg_t            shadow    [NREG];
  cfg_t            shadow_nx [NREG];
  cfg_t            active    [NREG];
  logic [IDXW-1:0] wr_idx;
  logic            wr_en;

  assign cfg.cfg_ready = (state == ST_IDLE);
  assign cfg.cfg_busy  = (state == ST_COMMIT);
  assign cfg.cfg_state = state;

  assign wr_idx = cfg.cfg_idx;
  assign wr_en  = cfg.cfg_valid && (state == ST_IDLE) && (int'(wr_idx) < NREG);

  // Merging the write here lets a same-cycle commit pick up the word being written.
  always_comb begin
    shadow_nx = shadow;
    if (wr_en) begin
      shadow_nx[wr_idx] = cfg_unpack(cfg.cfg_data);
    end
  end

  always_ff @(posedge CLK or negedge GSR_N) begin
    if (!GSR_N) begin
      state <= ST_IDLE;
      for (int i = 0; i < NREG; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      shadow <= shadow_nx;
      case (state)
        ST_IDLE: begin
          if (cfg.cfg_commit) begin
            active <= shadow_nx;
            state  <= ST_COMMIT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    slice_reg_bit u_bit (
      .clk   (CLK),
      .gsr_n (GSR_N),
      .ce    (CE),
      .lsr   (LSR),
      .df    (DF[i]),
      .di    (DI[i]),
      .cfg   (active[i]),
      .q     (Q[i])
    );
  end

`ifdef SLICE_READBACK_EN
  logic rb_hit;

  assign rb_hit = (int'(rb_idx) < NREG);

  // Active is sampled at the capture edge, so a request in COMMIT sees the new word.
  always_ff @(posedge CLK or negedge GSR_N) begin
    if (!GSR_N) begin
      rb_valid <= 1'b0;
      rb_data  <= '0;
    end else begin
      rb_valid <= rb_req;
      if (rb_req) begin
        rb_data <= rb_hit ? {Q[rb_idx], active[rb_idx]} : '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_slice_reg_pair.sv
// Directed bench for slice_reg_pair: vector table for the datapath modes plus hand sequences for reset,
// commit timing, dropped writes (NREG=3 instance) and, with SLICE_READBACK_EN, readback.
module tb_slice_reg_pair;

  logic       CLK   = 1'b0;
  logic       GSR_N = 1'b0;
  logic       CE    = 1'b0;
  logic       LSR   = 1'b0;
  logic [1:0] DF    = 2'b00;
  logic [1:0] DI    = 2'b00;
  logic [1:0] Q;
  logic [2:0] DF3   = 3'b000;
  logic [2:0] DI3   = 3'b000;
  logic [2:0] Q3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  slice_reg_pair_if #(.NREG(2), .CFGW(6)) cfg_if  ();
  slice_reg_pair_if #(.NREG(3), .CFGW(6)) cfg3_if ();

`ifdef SLICE_READBACK_EN
  logic       rb_req   = 1'b0;
  logic [0:0] rb_idx   = 1'b0;
  logic       rb_valid;
  logic [6:0] rb_data;
  logic       rb_req3  = 1'b0;
  logic [1:0] rb_idx3  = 2'b00;
  logic       rb_valid3;
  logic [6:0] rb_data3;
`endif

  slice_reg_pair #(.NREG(2), .CFGW(6)) dut (
    .CLK   (CLK),
    .GSR_N (GSR_N),
    .CE    (CE),
    .LSR   (LSR),
    .DF    (DF),
    .DI    (DI),
    .Q     (Q),
    .cfg   (cfg_if)
`ifdef SLICE_READBACK_EN
    ,
    .rb_req   (rb_req),
    .rb_idx   (rb_idx),
    .rb_valid (rb_valid),
    .rb_data  (rb_data)
`endif
  );

  slice_reg_pair #(.NREG(3), .CFGW(6)) dut3 (
    .CLK   (CLK),
    .GSR_N (GSR_N),
    .CE    (CE),
    .LSR   (LSR),
    .DF    (DF3),
    .DI    (DI3),
    .Q     (Q3),
    .cfg   (cfg3_if)
`ifdef SLICE_READBACK_EN
    ,
    .rb_req   (rb_req3),
    .rb_idx   (rb_idx3),
    .rb_valid (rb_valid3),
    .rb_data  (rb_data3)
`endif
  );

  typedef struct {
    logic [5:0] c0;
    logic [5:0] c1;
    logic       lsr;
    logic       ce;
    logic [1:0] df;
    logic [1:0] di;
    logic [1:0] exp_pre;
    logic [1:0] exp_post;
  } vec_t;

  vec_t vt [13];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [5:0] data, input logic commit);
    check("cfg_ready before write", 16'(cfg_if.cfg_ready), 16'd1);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_idx    = idx[0:0];
    cfg_if.cfg_data   = data;
    cfg_if.cfg_commit = commit;
    tick();
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_commit = 1'b0;
  endtask

  task automatic cfg3_write(input logic [1:0] idx, input logic [5:0] data, input logic commit);
    cfg3_if.cfg_valid  = 1'b1;
    cfg3_if.cfg_idx    = idx;
    cfg3_if.cfg_data   = data;
    cfg3_if.cfg_commit = commit;
    tick();
    cfg3_if.cfg_valid  = 1'b0;
    cfg3_if.cfg_commit = 1'b0;
  endtask

  initial begin
    logic [5:0] cur0;
    logic [5:0] cur1;

    cfg_if.cfg_valid   = 1'b0;
    cfg_if.cfg_idx     = 1'b0;
    cfg_if.cfg_data    = 6'b0;
    cfg_if.cfg_commit  = 1'b0;
    cfg3_if.cfg_valid  = 1'b0;
    cfg3_if.cfg_idx    = 2'b00;
    cfg3_if.cfg_data   = 6'b0;
    cfg3_if.cfg_commit = 1'b0;

    vt[0]  = '{6'b000001, 6'b000010, 1'b0, 1'b1, 2'b01, 2'b00, 2'b10, 2'b01};
    vt[1]  = '{6'b000001, 6'b000010, 1'b0, 1'b0, 2'b10, 2'b11, 2'b01, 2'b01};
    vt[2]  = '{6'b010000, 6'b010001, 1'b1, 1'b0, 2'b00, 2'b00, 2'b10, 2'b10};
    vt[3]  = '{6'b010000, 6'b010001, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 2'b10};
    vt[4]  = '{6'b000001, 6'b000000, 1'b1, 1'b0, 2'b00, 2'b00, 2'b10, 2'b01};
    vt[5]  = '{6'b000100, 6'b000100, 1'b1, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10};
    vt[6]  = '{6'b000100, 6'b000100, 1'b1, 1'b0, 2'b00, 2'b01, 2'b10, 2'b01};
    vt[7]  = '{6'b010100, 6'b010100, 1'b1, 1'b0, 2'b00, 2'b10, 2'b10, 2'b10};
    vt[8]  = '{6'b010100, 6'b010100, 1'b1, 1'b0, 2'b00, 2'b01, 2'b01, 2'b01};
    vt[9]  = '{6'b100000, 6'b100000, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 2'b11};
    vt[10] = '{6'b100000, 6'b100000, 1'b0, 1'b0, 2'b10, 2'b00, 2'b11, 2'b10};
    vt[11] = '{6'b100010, 6'b100010, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b01};
    vt[12] = '{6'b100011, 6'b100010, 1'b1, 1'b1, 2'b11, 2'b11, 2'b00, 2'b01};

    // Reset state
    #3;
    check("reset Q", 16'(Q), 16'd0);
    check("reset Q3", 16'(Q3), 16'd0);
    check("reset cfg_ready", 16'(cfg_if.cfg_ready), 16'd1);
    check("reset cfg_busy", 16'(cfg_if.cfg_busy), 16'd0);
    check("reset cfg_state", 16'(cfg_if.cfg_state), 16'd0);
`ifdef SLICE_READBACK_EN
    check("reset rb_valid", 16'(rb_valid), 16'd0);
    check("reset rb_data", 16'(rb_data), 16'd0);
    check("reset rb_valid3", 16'(rb_valid3), 16'd0);
`endif
    #9;
    GSR_N = 1'b1;
    #1;
    check("Q after release", 16'(Q), 16'd0);
    tick();

    // Mid-run GSR with Q=11 and a committed SET config
    cfg_write(2'd0, 6'b000001, 1'b1);
    tick();
    CE = 1'b1;
    DF = 2'b11;
    tick();
    check("load Q=11", 16'(Q), 16'd3);
    #2;
    GSR_N = 1'b0;
    #1;
    check("GSR async Q", 16'(Q), 16'd0);
    check("GSR cfg_ready", 16'(cfg_if.cfg_ready), 16'd1);
    check("GSR cfg_busy", 16'(cfg_if.cfg_busy), 16'd0);
    #2;
    GSR_N = 1'b1;
    #1;
    check("Q held 0 after GSR release", 16'(Q), 16'd0);
    CE  = 1'b0;
    DF  = 2'b00;
    LSR = 1'b1;
    tick();
    check("LSR with cleared cfg", 16'(Q), 16'd0);
    LSR = 1'b0;

    // Basic config write + commit timing
    cfg_write(2'd0, 6'b000001, 1'b0);
    cfg_write(2'd1, 6'b000010, 1'b0);
    cfg_if.cfg_commit = 1'b1;
    tick();
    cfg_if.cfg_commit = 1'b0;
    check("commit busy", 16'(cfg_if.cfg_busy), 16'd1);
    check("commit ready", 16'(cfg_if.cfg_ready), 16'd0);
    check("commit state", 16'(cfg_if.cfg_state), 16'd1);
    tick();
    check("post-commit busy", 16'(cfg_if.cfg_busy), 16'd0);
    check("post-commit ready", 16'(cfg_if.cfg_ready), 16'd1);
    LSR = 1'b1;
    tick();
    check("LSR SET Q0", 16'(Q), 16'd1);
    LSR = 1'b0;
    CE  = 1'b1;
    DI  = 2'b10;
    #1;
    check("D->Q latency pre", 16'(Q), 16'd1);
    tick();
    check("SEL DI Q=10", 16'(Q), 16'd2);

    // Datapath vector table
    cur0 = 6'b000001;
    cur1 = 6'b000010;
    for (int i = 0; i < 13; i++) begin
      if (vt[i].c0 != cur0 || vt[i].c1 != cur1) begin
        LSR = 1'b0;
        CE  = 1'b0;
        DF  = 2'b00;
        DI  = 2'b00;
        cfg_write(2'd0, vt[i].c0, 1'b0);
        cfg_write(2'd1, vt[i].c1, 1'b1);
        tick();
        cur0 = vt[i].c0;
        cur1 = vt[i].c1;
      end
      LSR = vt[i].lsr;
      CE  = vt[i].ce;
      DF  = vt[i].df;
      DI  = vt[i].di;
      #1;
      check($sformatf("vec%0d pre-edge Q", i), 16'(Q), 16'(vt[i].exp_pre));
      tick();
      check($sformatf("vec%0d post-edge Q", i), 16'(Q), 16'(vt[i].exp_post));
    end

    // Commit held high through COMMIT must not re-enter COMMIT
    LSR = 1'b0;
    CE  = 1'b0;
    DF  = 2'b00;
    DI  = 2'b00;
    cfg_if.cfg_commit = 1'b1;
    tick();
    check("held commit busy", 16'(cfg_if.cfg_busy), 16'd1);
    tick();
    check("held commit ignored busy", 16'(cfg_if.cfg_busy), 16'd0);
    check("held commit ignored ready", 16'(cfg_if.cfg_ready), 16'd1);
    cfg_if.cfg_commit = 1'b0;
    tick();
    check("idle after held commit", 16'(cfg_if.cfg_busy), 16'd0);

`ifdef SLICE_READBACK_EN
    DI = 2'b10;
    tick();
    check("rb setup Q", 16'(Q), 16'd2);
    rb_req = 1'b1;
    rb_idx = 1'b1;
    tick();
    rb_req = 1'b0;
    check("rb_valid pulse", 16'(rb_valid), 16'd1);
    check("rb_data idx1", 16'(rb_data), 16'(7'b1100010));
    tick();
    check("rb_valid drop", 16'(rb_valid), 16'd0);
    cfg_write(2'd1, 6'b000001, 1'b1);
    check("rb commit busy", 16'(cfg_if.cfg_busy), 16'd1);
    rb_req = 1'b1;
    tick();
    rb_req = 1'b0;
    check("rb during COMMIT valid", 16'(rb_valid), 16'd1);
    check("rb during COMMIT data", 16'(rb_data), 16'(7'b1000001));
`endif

    // Out-of-range index on the NREG=3 instance is dropped
    LSR = 1'b0;
    CE  = 1'b0;
    cfg3_write(2'd3, 6'b000001, 1'b0);
    cfg3_if.cfg_commit = 1'b1;
    tick();
    cfg3_if.cfg_commit = 1'b0;
    tick();
    LSR = 1'b1;
    tick();
    check("idx3 write dropped", 16'(Q3), 16'd0);
    cfg3_write(2'd2, 6'b000001, 1'b1);
    check("idx2 before effect", 16'(Q3), 16'd0);
    tick();
    check("idx2 SET effective", 16'(Q3), 16'd4);
    LSR = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
